// File: rtl/lc3_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : lc3_ctrl_fsm
//  Brief    : LC-3 microsequencer (fetch, decode, ADD/AND/NOT/LEA/LD/LDR/
//             ST/STR/BR/JMP) with ready-handshake memory waits and an
//             optional memory timeout that halts the sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
module lc3_ctrl_fsm #(
  parameter int WAIT_LIMIT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [3:0] ir_opcode,
  input  logic       ben,
  input  logic       mem_ready,
  output logic       ld_mar,
  output logic       ld_mdr,
  output logic       ld_ir,
  output logic       ld_pc,
  output logic       ld_reg,
  output logic       ld_cc,
  output logic       ld_ben,
  output logic       gate_pc,
  output logic       gate_mdr,
  output logic       gate_alu,
  output logic       gate_marmux,
  output logic       mem_en,
  output logic       mem_we,
  output logic [1:0] pcmux_sel,
  output logic       addr1mux_sel,
  output logic [1:0] addr2mux_sel,
  output logic [1:0] aluk,
  output logic [5:0] state,
  output logic       instr_done,
  output logic       halted,
  output logic       mem_err
);

  // State numbers follow the LC-3 microarchitecture numbering.
  localparam logic [5:0] c_S0   = 6'd0;
  localparam logic [5:0] c_S1   = 6'd1;
  localparam logic [5:0] c_S2   = 6'd2;
  localparam logic [5:0] c_S3   = 6'd3;
  localparam logic [5:0] c_S5   = 6'd5;
  localparam logic [5:0] c_S6   = 6'd6;
  localparam logic [5:0] c_S7   = 6'd7;
  localparam logic [5:0] c_S9   = 6'd9;
  localparam logic [5:0] c_S12  = 6'd12;
  localparam logic [5:0] c_S14  = 6'd14;
  localparam logic [5:0] c_S16  = 6'd16;
  localparam logic [5:0] c_S18  = 6'd18;
  localparam logic [5:0] c_S22  = 6'd22;
  localparam logic [5:0] c_S23  = 6'd23;
  localparam logic [5:0] c_S25  = 6'd25;
  localparam logic [5:0] c_S27  = 6'd27;
  localparam logic [5:0] c_S32  = 6'd32;
  localparam logic [5:0] c_S33  = 6'd33;
  localparam logic [5:0] c_S35  = 6'd35;
  localparam logic [5:0] c_HALT = 6'd63;

  localparam logic [15:0] c_WAIT_LIMIT = 16'(WAIT_LIMIT);
  localparam bit          c_TIMEOUT_EN = (WAIT_LIMIT > 0);

  logic [5:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        w_in_wait;
  logic        w_next_is_wait;

  assign w_in_wait      = (state_q == c_S33) || (state_q == c_S25) || (state_q == c_S16);
  assign w_next_is_wait = (state_d == c_S33) || (state_d == c_S25) || (state_d == c_S16);

  // Next-state, wait-counter and timeout-flag computation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      c_S18: if (run) state_d = c_S33;
      c_S33: if (mem_ready) state_d = c_S35;
      c_S35: state_d = c_S32;
      c_S32: begin
        case (ir_opcode)
          4'b0001: state_d = c_S1;
          4'b0101: state_d = c_S5;
          4'b1001: state_d = c_S9;
          4'b1110: state_d = c_S14;
          4'b0010: state_d = c_S2;
          4'b0110: state_d = c_S6;
          4'b0011: state_d = c_S3;
          4'b0111: state_d = c_S7;
          4'b0000: state_d = c_S0;
          4'b1100: state_d = c_S12;
          default: state_d = c_HALT;
        endcase
      end
      c_S1, c_S5, c_S9, c_S14: state_d = c_S18;
      c_S2, c_S6:  state_d = c_S25;
      c_S25:       if (mem_ready) state_d = c_S27;
      c_S27:       state_d = c_S18;
      c_S3, c_S7:  state_d = c_S23;
      c_S23:       state_d = c_S16;
      c_S16:       if (mem_ready) state_d = c_S18;
      c_S0:        state_d = ben ? c_S22 : c_S18;
      c_S22, c_S12: state_d = c_S18;
      c_HALT:      state_d = c_HALT;
      default:     state_d = c_HALT;
    endcase

    // A stalled memory wait counts up; reaching the limit aborts to HALT.
    // mem_ready in the same cycle takes the normal path above instead.
    if (w_in_wait && !mem_ready) begin
      if (c_TIMEOUT_EN && ((cnt_q + 16'd1) == c_WAIT_LIMIT)) begin
        state_d = c_HALT;
        err_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end

    // Each fresh entry into a wait state starts a new timeout window.
    if (w_next_is_wait && (state_d != state_q)) begin
      cnt_d = 16'd0;
    end
  end

  // State, counter and sticky error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= c_S18;
      cnt_q   <= 16'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Datapath control decode from the current state.
  always_comb begin
    ld_mar       = 1'b0;
    ld_mdr       = 1'b0;
    ld_ir        = 1'b0;
    ld_pc        = 1'b0;
    ld_reg       = 1'b0;
    ld_cc        = 1'b0;
    ld_ben       = 1'b0;
    gate_pc      = 1'b0;
    gate_mdr     = 1'b0;
    gate_alu     = 1'b0;
    gate_marmux  = 1'b0;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    pcmux_sel    = 2'b00;
    addr1mux_sel = 1'b0;
    addr2mux_sel = 2'b00;
    aluk         = 2'b00;
    case (state_q)
      c_S18: if (run) begin
        gate_pc = 1'b1;
        ld_mar  = 1'b1;
        ld_pc   = 1'b1;
      end
      c_S33: begin
        mem_en = 1'b1;
        ld_mdr = mem_ready;
      end
      c_S35: begin
        gate_mdr = 1'b1;
        ld_ir    = 1'b1;
      end
      c_S32: ld_ben = 1'b1;
      c_S1, c_S5, c_S9: begin
        aluk     = (state_q == c_S1) ? 2'b00 : (state_q == c_S5) ? 2'b01 : 2'b10;
        gate_alu = 1'b1;
        ld_reg   = 1'b1;
        ld_cc    = 1'b1;
      end
      c_S14: begin
        addr2mux_sel = 2'b10;
        gate_marmux  = 1'b1;
        ld_reg       = 1'b1;
      end
      c_S2, c_S3: begin
        addr2mux_sel = 2'b10;
        gate_marmux  = 1'b1;
        ld_mar       = 1'b1;
      end
      c_S6, c_S7: begin
        addr1mux_sel = 1'b1;
        addr2mux_sel = 2'b01;
        gate_marmux  = 1'b1;
        ld_mar       = 1'b1;
      end
      c_S25: begin
        mem_en = 1'b1;
        ld_mdr = mem_ready;
      end
      c_S27: begin
        gate_mdr = 1'b1;
        ld_reg   = 1'b1;
        ld_cc    = 1'b1;
      end
      c_S23: begin
        aluk     = 2'b11;
        gate_alu = 1'b1;
        ld_mdr   = 1'b1;
      end
      c_S16: begin
        mem_en = 1'b1;
        mem_we = 1'b1;
      end
      c_S22: begin
        addr2mux_sel = 2'b10;
        pcmux_sel    = 2'b10;
        ld_pc        = 1'b1;
      end
      c_S12: begin
        addr1mux_sel = 1'b1;
        pcmux_sel    = 2'b10;
        ld_pc        = 1'b1;
      end
      default: ;
    endcase
  end

  assign state      = state_q;
  assign halted     = (state_q == c_HALT);
  assign mem_err    = err_q;
  assign instr_done = (state_q != c_S18) && (state_d == c_S18);

endmodule
`default_nettype wire

// File: tb/tb_lc3_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lc3_ctrl_fsm
//  Brief    : Directed self-checking bench for lc3_ctrl_fsm. Two instances
//             share stimulus: one without timeout, one with WAIT_LIMIT=4.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lc3_ctrl_fsm;

  // Strobe vector bit weights: {ld_mar,ld_mdr,ld_ir,ld_pc,ld_reg,ld_cc,
  // ld_ben,gate_pc,gate_mdr,gate_alu,gate_marmux,mem_en,mem_we}
  localparam logic [12:0] B_MAR = 13'h1000, B_MDR = 13'h0800, B_IR  = 13'h0400,
                          B_PC  = 13'h0200, B_REG = 13'h0100, B_CC  = 13'h0080,
                          B_BEN = 13'h0040, G_PC  = 13'h0020, G_MDR = 13'h0010,
                          G_ALU = 13'h0008, G_MM  = 13'h0004, M_EN  = 13'h0002,
                          M_WE  = 13'h0001, NONE  = 13'h0000;

  logic clk = 1'b0;
  logic rst, run, ben, mem_ready;
  logic [3:0] ir_opcode;

  logic ld_mar, ld_mdr, ld_ir, ld_pc, ld_reg, ld_cc, ld_ben;
  logic gate_pc, gate_mdr, gate_alu, gate_marmux, mem_en, mem_we;
  logic [1:0] pcmux_sel, addr2mux_sel, aluk;
  logic addr1mux_sel, instr_done, halted, mem_err;
  logic [5:0] state;

  logic t_ld_mar, t_ld_mdr, t_ld_ir, t_ld_pc, t_ld_reg, t_ld_cc, t_ld_ben;
  logic t_gate_pc, t_gate_mdr, t_gate_alu, t_gate_marmux, t_mem_en, t_mem_we;
  logic [1:0] t_pcmux_sel, t_addr2mux_sel, t_aluk;
  logic t_addr1mux_sel, t_instr_done, t_halted, t_mem_err;
  logic [5:0] t_state;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lc3_ctrl_fsm #(.WAIT_LIMIT(0)) dut (
    .clk(clk), .rst(rst), .run(run), .ir_opcode(ir_opcode), .ben(ben),
    .mem_ready(mem_ready), .ld_mar(ld_mar), .ld_mdr(ld_mdr), .ld_ir(ld_ir),
    .ld_pc(ld_pc), .ld_reg(ld_reg), .ld_cc(ld_cc), .ld_ben(ld_ben),
    .gate_pc(gate_pc), .gate_mdr(gate_mdr), .gate_alu(gate_alu),
    .gate_marmux(gate_marmux), .mem_en(mem_en), .mem_we(mem_we),
    .pcmux_sel(pcmux_sel), .addr1mux_sel(addr1mux_sel),
    .addr2mux_sel(addr2mux_sel), .aluk(aluk), .state(state),
    .instr_done(instr_done), .halted(halted), .mem_err(mem_err)
  );

  lc3_ctrl_fsm #(.WAIT_LIMIT(4)) dut_t (
    .clk(clk), .rst(rst), .run(run), .ir_opcode(ir_opcode), .ben(ben),
    .mem_ready(mem_ready), .ld_mar(t_ld_mar), .ld_mdr(t_ld_mdr), .ld_ir(t_ld_ir),
    .ld_pc(t_ld_pc), .ld_reg(t_ld_reg), .ld_cc(t_ld_cc), .ld_ben(t_ld_ben),
    .gate_pc(t_gate_pc), .gate_mdr(t_gate_mdr), .gate_alu(t_gate_alu),
    .gate_marmux(t_gate_marmux), .mem_en(t_mem_en), .mem_we(t_mem_we),
    .pcmux_sel(t_pcmux_sel), .addr1mux_sel(t_addr1mux_sel),
    .addr2mux_sel(t_addr2mux_sel), .aluk(t_aluk), .state(t_state),
    .instr_done(t_instr_done), .halted(t_halted), .mem_err(t_mem_err)
  );

  wire [12:0] strobes = {ld_mar, ld_mdr, ld_ir, ld_pc, ld_reg, ld_cc, ld_ben,
                         gate_pc, gate_mdr, gate_alu, gate_marmux, mem_en, mem_we};
  // {pcmux[1:0], addr1, addr2[1:0], aluk[1:0]}
  wire [6:0]  muxes  = {pcmux_sel, addr1mux_sel, addr2mux_sel, aluk};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full check of the no-timeout instance in the current cycle.
  task automatic chk_cyc(input string tag, input logic [5:0] st, input logic [12:0] stb,
                         input logic [6:0] mx, input logic done);
    chk({tag, ".state"}, 32'(state), 32'(st));
    chk({tag, ".strobes"}, 32'(strobes), 32'(stb));
    chk({tag, ".mux"}, 32'(muxes), 32'(mx));
    chk({tag, ".done"}, 32'(instr_done), 32'(done));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Runs 18,33,35,32 with mem_ready=1 and ends settled in the decoded state.
  task automatic fetch(input logic [3:0] op);
    ir_opcode = op;
    #1;
    chk_cyc("f18", 6'd18, G_PC | B_MAR | B_PC, 7'b00_0_00_00, 1'b0);
    tick;
    chk_cyc("f33", 6'd33, M_EN | B_MDR, 7'b0, 1'b0);
    tick;
    chk_cyc("f35", 6'd35, G_MDR | B_IR, 7'b0, 1'b0);
    tick;
    chk_cyc("f32", 6'd32, B_BEN, 7'b0, 1'b0);
    tick;
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; ben = 1'b0; mem_ready = 1'b1; ir_opcode = 4'b0001;
    tick;
    chk("rst.state", 32'(state), 32'd18);
    chk("rst.mem_err", 32'(mem_err), 32'd0);
    chk("rst.halted", 32'(halted), 32'd0);
    rst = 1'b0;
    tick; tick;
    chk_cyc("idle", 6'd18, NONE, 7'b0, 1'b0);

    // ADD
    run = 1'b1;
    fetch(4'b0001);
    chk_cyc("add1", 6'd1, G_ALU | B_REG | B_CC, 7'b00_0_00_00, 1'b1);
    tick;

    // AND
    fetch(4'b0101);
    chk_cyc("and5", 6'd5, G_ALU | B_REG | B_CC, 7'b00_0_00_01, 1'b1);
    tick;

    // BR taken
    ben = 1'b1;
    fetch(4'b0000);
    chk_cyc("br0t", 6'd0, NONE, 7'b0, 1'b0);
    tick;
    chk_cyc("br22", 6'd22, B_PC, 7'b10_0_10_00, 1'b1);
    tick;

    // BR not taken
    ben = 1'b0;
    fetch(4'b0000);
    chk_cyc("br0n", 6'd0, NONE, 7'b0, 1'b1);
    tick;
    chk("brn.back", 32'(state), 32'd18);

    // LD with three stalled cycles in S25
    fetch(4'b0010);
    chk_cyc("ld2", 6'd2, G_MM | B_MAR, 7'b00_0_10_00, 1'b0);
    mem_ready = 1'b0;
    tick;
    chk_cyc("ld25a", 6'd25, M_EN, 7'b0, 1'b0);
    tick;
    chk_cyc("ld25b", 6'd25, M_EN, 7'b0, 1'b0);
    tick;
    chk_cyc("ld25c", 6'd25, M_EN, 7'b0, 1'b0);
    tick;
    mem_ready = 1'b1;
    #1;
    chk_cyc("ld25d", 6'd25, M_EN | B_MDR, 7'b0, 1'b0);
    tick;
    chk_cyc("ld27", 6'd27, G_MDR | B_REG | B_CC, 7'b0, 1'b1);
    chk("ld27.t_state", 32'(t_state), 32'd27);
    tick;

    // STR
    fetch(4'b0111);
    chk_cyc("str7", 6'd7, G_MM | B_MAR, 7'b00_1_01_00, 1'b0);
    tick;
    chk_cyc("str23", 6'd23, G_ALU | B_MDR, 7'b00_0_00_11, 1'b0);
    tick;
    chk_cyc("str16", 6'd16, M_EN | M_WE, 7'b0, 1'b1);
    tick;

    // JMP
    fetch(4'b1100);
    chk_cyc("jmp12", 6'd12, B_PC, 7'b10_1_00_00, 1'b1);
    tick;

    // LEA: no condition-code load
    fetch(4'b1110);
    chk_cyc("lea14", 6'd14, G_MM | B_REG, 7'b00_0_10_00, 1'b1);
    tick;

    // ST interrupted by reset while in S16
    fetch(4'b0011);
    chk_cyc("st3", 6'd3, G_MM | B_MAR, 7'b00_0_10_00, 1'b0);
    tick;
    mem_ready = 1'b0;
    tick;
    chk_cyc("st16", 6'd16, M_EN | M_WE, 7'b0, 1'b0);
    rst = 1'b1;
    tick;
    chk("st.rst.state", 32'(state), 32'd18);
    chk("st.rst.mem_en", 32'(mem_en), 32'd0);
    chk("st.rst.mem_we", 32'(mem_we), 32'd0);
    rst = 1'b0;
    mem_ready = 1'b1;

    // Unsupported opcode halts after decode
    fetch(4'b1101);
    chk_cyc("halt", 6'd63, NONE, 7'b0, 1'b0);
    chk("halt.halted", 32'(halted), 32'd1);
    chk("halt.mem_err", 32'(mem_err), 32'd0);
    tick;
    chk("halt.hold", 32'(state), 32'd63);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("halt.rst", 32'(state), 32'd18);

    // Timeout: memory never ready from S33 onward
    #1;
    mem_ready = 1'b0;
    #1;
    tick;
    chk("to.c1", 32'(t_state), 32'd33);
    chk("to.c1.ld_mdr", 32'(t_ld_mdr), 32'd0);
    tick; tick; tick;
    chk("to.c4", 32'(t_state), 32'd33);
    tick;
    chk("to.halt.state", 32'(t_state), 32'd63);
    chk("to.halt.halted", 32'(t_halted), 32'd1);
    chk("to.halt.mem_err", 32'(t_mem_err), 32'd1);
    chk("to.nolimit.state", 32'(state), 32'd33);
    chk("to.nolimit.err", 32'(mem_err), 32'd0);
    tick;
    chk("to.sticky", 32'(t_mem_err), 32'd1);
    rst = 1'b1;
    tick;
    chk("to.rst.state", 32'(t_state), 32'd18);
    chk("to.rst.halted", 32'(t_halted), 32'd0);
    chk("to.rst.mem_err", 32'(t_mem_err), 32'd0);
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lc3_ctrl_fsm.md
Name: lc3_ctrl_fsm

Overview:
- Microsequencer for the LC-3 instruction cycle. It drives the load, gate and mux-select strobes for the datapath, including the condition-code/BEN register block (ld_cc, ld_ben).
- Covers fetch, decode and the subset ADD, AND, NOT, LEA, LD, LDR, ST, STR, BR and JMP. Any other opcode halts the sequencer.
- Memory accesses use a ready handshake, with an optional timeout.

Parameters:
WAIT_LIMIT, 0, consecutive mem_ready-low cycles allowed in a memory wait state before halting; 0 disables the timeout.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous reset, active-high
run  input  1  enables instruction fetch
ir_opcode  input  4  IR[15:12]
ben  input  1  branch-enable flag from the condition-code block
mem_ready  input  1  memory access complete (LC-3 "R")
ld_mar, ld_mdr, ld_ir, ld_pc, ld_reg, ld_cc, ld_ben  output  1 each  register load strobes
gate_pc, gate_mdr, gate_alu, gate_marmux  output  1 each  bus drivers; at most one high per cycle
mem_en  output  1  memory access request
mem_we  output  1  memory write
pcmux_sel  output  2  00 PC+1, 10 address adder
addr1mux_sel  output  1  0 PC, 1 BaseR
addr2mux_sel  output  2  00 zero, 01 offset6, 10 offset9
aluk  output  2  00 ADD, 01 AND, 10 NOT, 11 PASSA
state  output  6  current state number (LC-3 numbering)
instr_done  output  1  high in the final cycle of each instruction
halted  output  1  high while in HALT
mem_err  output  1  sticky flag: memory timeout occurred

Behaviour:
- Outputs are a combinational decode of the state register (instr_done also depends on next state). Every output defaults to 0 unless listed below.
- Reset: state=18, wait counter=0, mem_err=0. All outputs take their state-18 values; rst takes priority in every state, including wait states.
- S18: if run=0, hold with no strobes asserted. If run=1: gate_pc, ld_mar, ld_pc, pcmux=00 -> S33.
- S33: mem_en=1. On mem_ready: ld_mdr=1 -> S35. Otherwise hold.
- S35: gate_mdr, ld_ir -> S32.
- S32: ld_ben=1. Next state by opcode:
  - 0001->S1, 0101->S5, 1001->S9, 1110->S14
  - 0010->S2, 0110->S6, 0011->S3, 0111->S7
  - 0000->S0, 1100->S12
  - all others -> HALT (state 63).
- S1/S5/S9: aluk=00/01/10, gate_alu, ld_reg, ld_cc -> S18.
- S14 (LEA): addr1=0, addr2=10, gate_marmux, ld_reg -> S18. No ld_cc.
- S2 (LD): addr1=0, addr2=10, gate_marmux, ld_mar -> S25.
- S6 (LDR): addr1=1, addr2=01, gate_marmux, ld_mar -> S25.
- S25: mem_en=1. On mem_ready: ld_mdr -> S27. Otherwise hold.
- S27: gate_mdr, ld_reg, ld_cc -> S18.
- S3 (ST): same address setup as S2, -> S23. S7 (STR): same address setup as S6, -> S23.
- S23: aluk=11, gate_alu, ld_mdr -> S16.
- S16: mem_en=1, mem_we=1. On mem_ready -> S18. Otherwise hold.
- S0 (BR): samples ben, which was loaded at the end of S32. ben=1 -> S22; ben=0 -> S18.
- S22: addr1=0, addr2=10, pcmux=10, ld_pc -> S18.
- S12 (JMP): addr1=1, addr2=00, pcmux=10, ld_pc -> S18.
- HALT: halted=1, no strobes. Leaves only on rst.
- instr_done = (state!=18) && (next_state==18). It is never asserted on a transition into HALT.
- Timeout (WAIT_LIMIT>0), 16-bit counter:
  - Counter clears on entry to S33, S25 or S16.
  - Counter increments each cycle in those states while mem_ready=0.
  - When it would reach WAIT_LIMIT, next state is HALT and mem_err is set.
  - mem_ready=1 in the same cycle wins over the timeout.
  - With WAIT_LIMIT=0, wait states hold indefinitely.
- run is only sampled in S18. Deasserting run mid-instruction lets the instruction complete.

Test Plan:
- rst, run=1, mem_ready=1, opcode 0001 -> states 18,33,35,32,1,18. ld_cc and instr_done high only in the S1 cycle; ld_ben only in S32.
- opcode 0000, ben=1 -> 0,22,18 with ld_pc=1, pcmux=10 in S22. With ben=0 -> 0,18, ld_pc=0, instr_done=1 in S0.
- opcode 0010, mem_ready held low 3 cycles in S25 -> S25 lasts 4 cycles with mem_en=1 throughout and ld_mdr only in the 4th. Then S27 with ld_reg=ld_cc=1.
- opcode 0111 -> 7,23,16. mem_we=1 only in S16; addr2=01 in S7; aluk=11 in S23.
- WAIT_LIMIT=4, mem_ready=0 from S33 onward -> 4 cycles in S33, then state=63, halted=1, mem_err=1. rst -> state=18, halted=0, mem_err=0.
- run=0 after rst -> S18 held, all strobes 0. Opcode 1101 -> HALT after S32. rst asserted during S16 -> next cycle S18 with mem_en=mem_we=0.
